// File: rtl/mem_stage_mc_if.sv
// Pipeline-side and memory-side signals of the multi-cycle memory stage.
// The slave modport is the stage itself; master is the upstream pipeline plus memory.
interface mem_stage_mc_if #(
  parameter int DW = 16
);
  logic          in_valid;
  logic [DW-1:0] in_addr;
  logic [DW-1:0] in_wdata;
  logic          in_rd;
  logic          in_wr;
  logic          stall;
  logic          out_valid;
  logic [DW-1:0] out_rdata;
  logic [DW-1:0] out_addr;
  logic          err;

  logic          mem_req;
  logic          mem_we;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          mem_err;

  modport slave (
    input  in_valid, in_addr, in_wdata, in_rd, in_wr,
    input  mem_ack, mem_rdata, mem_err,
    output stall, out_valid, out_rdata, out_addr, err,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output in_valid, in_addr, in_wdata, in_rd, in_wr,
    output mem_ack, mem_rdata, mem_err,
    input  stall, out_valid, out_rdata, out_addr, err,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_stage_mc.sv
// Multi-cycle load/store stage between the EX/MEM and MEM/WB registers.
// Define MEM_STAGE_TIMEOUT_EN to abort accesses that wait TO_CYC cycles for mem_ack.
//
//   state   | meaning
//   IDLE    | classify the presented instruction; faults and pass-throughs retire next cycle
//   WAIT    | request outstanding, hold mem_* and stall until ack (or timeout)
module mem_stage_mc #(
  parameter int DW     = 16,
  parameter int TO_CYC = 64
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  mem_stage_mc_if.slave bus_if
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic [0:0]    state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [DW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          out_valid_q, out_valid_d;
  logic          err_q, err_d;
  logic [DW-1:0] out_rdata_q, out_rdata_d;
  logic [DW-1:0] out_addr_q, out_addr_d;

  logic is_mem;
  logic is_fault;
  logic is_access;
  logic timeout;

  assign is_mem    = bus_if.in_rd | bus_if.in_wr;
  assign is_fault  = (bus_if.in_rd & bus_if.in_wr) | (bus_if.in_addr[0] & is_mem);
  assign is_access = is_mem & ~is_fault;

`ifdef MEM_STAGE_TIMEOUT_EN
  localparam int CW = $clog2(TO_CYC + 1);

  logic [CW-1:0] wcnt_q, wcnt_d;

  // Held at zero in IDLE so every WAIT starts counting from 0.
  always_comb begin
    wcnt_d = wcnt_q;
    if (state_q == ST_IDLE) begin
      wcnt_d = '0;
    end else if (wcnt_q != CW'(TO_CYC)) begin
      wcnt_d = wcnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wcnt_q <= '0;
    end else begin
      wcnt_q <= wcnt_d;
    end
  end

  assign timeout = (state_q == ST_WAIT) & (wcnt_q == CW'(TO_CYC));
`else
  logic unused_to_cyc;
  assign unused_to_cyc = |TO_CYC;
  assign timeout       = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    out_valid_d = 1'b0;
    err_d       = 1'b0;
    out_rdata_d = '0;
    out_addr_d  = out_addr_q;

    case (state_q)
      ST_IDLE: begin
        if (bus_if.in_valid) begin
          out_addr_d = bus_if.in_addr;
          if (is_access) begin
            state_d     = ST_WAIT;
            mem_req_d   = 1'b1;
            mem_we_d    = bus_if.in_wr;
            mem_addr_d  = bus_if.in_addr;
            mem_wdata_d = bus_if.in_wdata;
          end else begin
            out_valid_d = 1'b1;
            err_d       = is_fault;
          end
        end
      end

      ST_WAIT: begin
        // An ack in the timeout cycle still completes normally.
        if (bus_if.mem_ack) begin
          state_d     = ST_IDLE;
          mem_req_d   = 1'b0;
          out_valid_d = 1'b1;
          err_d       = bus_if.mem_err;
          if (!mem_we_q && !bus_if.mem_err) begin
            out_rdata_d = bus_if.mem_rdata;
          end
        end else if (timeout) begin
          state_d     = ST_IDLE;
          mem_req_d   = 1'b0;
          out_valid_d = 1'b1;
          err_d       = 1'b1;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      out_rdata_q <= '0;
      out_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      out_rdata_q <= out_rdata_d;
      out_addr_q  <= out_addr_d;
    end
  end

  // Stall falls in the completion cycle so upstream advances on the same edge.
  assign bus_if.stall = ((state_q == ST_IDLE) & bus_if.in_valid & is_access) |
                        ((state_q == ST_WAIT) & ~bus_if.mem_ack & ~timeout);

  assign bus_if.mem_req   = mem_req_q;
  assign bus_if.mem_we    = mem_we_q;
  assign bus_if.mem_addr  = mem_addr_q;
  assign bus_if.mem_wdata = mem_wdata_q;
  assign bus_if.out_valid = out_valid_q;
  assign bus_if.err       = err_q;
  assign bus_if.out_rdata = out_rdata_q;
  assign bus_if.out_addr  = out_addr_q;

endmodule
